// File: rtl/timebase_stepper.sv
// timebase_stepper
//
// Divides clk by a runtime prescaler (tick period P+1 cycles) and advances a
// TIME_LENGTH-bit timestamp once per period. Three counting modes: FREE
// (wrap, overflow is sticky), SATURATE (halt at all-ones) and ONESHOT (halt
// when the timestamp equals limit). CHANNELS capture registers latch the
// pre-edge timestamp on a per-channel strobe.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   prescaler  divide value P
//   run        count enable (ignored while halted)
//   mode       0 FREE, 1 SATURATE, 2 ONESHOT, 3 FREE
//   limit      ONESHOT terminal value
//   clear      synchronous clear of counter state (captures untouched)
//   capture    per-channel capture strobe
//   cap_ack    per-channel valid clear
//   data       current timestamp
//   tick       one-cycle pulse in the cycle data shows a new value
//   overflow   sticky wrap/saturation flag
//   done       sticky, high while halted
//   cap_data   channel i at [i*TIME_LENGTH +: TIME_LENGTH]
//   cap_valid  per-channel capture-held flag
module timebase_stepper #(
  parameter int TIME_LENGTH     = 24,
  parameter int PRESCALER_WIDTH = 32,
  parameter int CHANNELS        = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PRESCALER_WIDTH-1:0]      prescaler,
  input  logic                            run,
  input  logic [1:0]                      mode,
  input  logic [TIME_LENGTH-1:0]          limit,
  input  logic                            clear,
  input  logic [CHANNELS-1:0]             capture,
  input  logic [CHANNELS-1:0]             cap_ack,
  output logic [TIME_LENGTH-1:0]          data,
  output logic                            tick,
  output logic                            overflow,
  output logic                            done,
  output logic [CHANNELS*TIME_LENGTH-1:0] cap_data,
  output logic [CHANNELS-1:0]             cap_valid
);

  typedef enum logic {
    COUNT = 1'b0,
    HALT  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_SATURATE = 2'd1;
  localparam logic [1:0] MODE_ONESHOT  = 2'd2;
  localparam logic [TIME_LENGTH-1:0] DATA_MAX = '1;

  state_t                       state, state_nxt;
  logic [PRESCALER_WIDTH-1:0]   div, div_nxt;
  logic [TIME_LENGTH-1:0]       data_nxt;
  logic                         tick_nxt;
  logic                         overflow_nxt;
  logic                         done_nxt;

  // Wrapping increment; the MSB of the result is the carry out of the
  // all-ones value, i.e. the wrap indication.
  function automatic logic [TIME_LENGTH:0] inc_wrap(input logic [TIME_LENGTH-1:0] v);
    return {1'b0, v} + {{TIME_LENGTH{1'b0}}, 1'b1};
  endfunction

  // Divider expiry; >= so that a prescaler lowered mid-period expires on
  // the next active edge instead of running through a full wrap.
  function automatic logic div_expired(input logic [PRESCALER_WIDTH-1:0] d,
                                       input logic [PRESCALER_WIDTH-1:0] p);
    return d >= p;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= COUNT;
      div      <= '0;
      data     <= '0;
      tick     <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      div      <= div_nxt;
      data     <= data_nxt;
      tick     <= tick_nxt;
      overflow <= overflow_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    logic [TIME_LENGTH:0] inc;
    state_nxt    = state;
    div_nxt      = div;
    data_nxt     = data;
    tick_nxt     = 1'b0;
    overflow_nxt = overflow;
    done_nxt     = done;
    inc          = inc_wrap(data);

    if (clear) begin
      state_nxt    = COUNT;
      div_nxt      = '0;
      data_nxt     = '0;
      overflow_nxt = 1'b0;
      done_nxt     = 1'b0;
    end else if (state == COUNT && run) begin
      // ONESHOT terminal check takes precedence over the divider, so the
      // halting edge neither advances div nor ticks.
      if (mode == MODE_ONESHOT && data == limit) begin
        state_nxt = HALT;
        done_nxt  = 1'b1;
      end else if (div_expired(div, prescaler)) begin
        div_nxt = '0;
        if (mode == MODE_SATURATE && data == DATA_MAX) begin
          // Saturation swallows the tick: data does not change.
          state_nxt    = HALT;
          overflow_nxt = 1'b1;
          done_nxt     = 1'b1;
        end else begin
          data_nxt = inc[TIME_LENGTH-1:0];
          tick_nxt = 1'b1;
          if (inc[TIME_LENGTH]) begin
            overflow_nxt = 1'b1;
          end
        end
      end else begin
        div_nxt = div + 1'b1;
      end
    end
  end

  // Capture channels sample the registered (pre-edge) timestamp and run
  // regardless of counter state or run. Capture beats ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_data  <= '0;
      cap_valid <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (capture[i]) begin
          cap_data[i*TIME_LENGTH +: TIME_LENGTH] <= data;
          cap_valid[i]                           <= 1'b1;
        end else if (cap_ack[i]) begin
          cap_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_timebase_stepper.sv
module tb_timebase_stepper;

  localparam int TL = 5;
  localparam int PW = 8;
  localparam int CH = 4;
  localparam logic [TL-1:0] MAXV = '1;

  logic              clk = 1'b0;
  logic              rst;
  logic [PW-1:0]     prescaler;
  logic              run;
  logic [1:0]        mode;
  logic [TL-1:0]     limit;
  logic              clear;
  logic [CH-1:0]     capture;
  logic [CH-1:0]     cap_ack;
  logic [TL-1:0]     data;
  logic              tick;
  logic              overflow;
  logic              done;
  logic [CH*TL-1:0]  cap_data;
  logic [CH-1:0]     cap_valid;

  timebase_stepper #(
    .TIME_LENGTH(TL),
    .PRESCALER_WIDTH(PW),
    .CHANNELS(CH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .prescaler(prescaler),
    .run(run),
    .mode(mode),
    .limit(limit),
    .clear(clear),
    .capture(capture),
    .cap_ack(cap_ack),
    .data(data),
    .tick(tick),
    .overflow(overflow),
    .done(done),
    .cap_data(cap_data),
    .cap_valid(cap_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TL-1:0]    data;
    logic             tick;
    logic             ovf;
    logic             done;
    logic [CH*TL-1:0] cap_data;
    logic [CH-1:0]    cap_valid;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: a timestamp, the number of active cycles spent in
  // the current tick period, a halted flag and sticky flags.
  logic [TL-1:0] m_data;
  int            m_phase;
  bit            m_halted;
  bit            m_ovf, m_done, m_tick;
  logic [TL-1:0] m_cap [CH];
  logic [CH-1:0] m_capv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one edge of the rules to the model with the currently driven
  // inputs, queue the expected outputs, then move to the next negedge.
  task automatic step();
    exp_t e;
    m_tick = 0;
    if (rst) begin
      m_data = '0; m_phase = 0; m_halted = 0; m_ovf = 0; m_done = 0;
      for (int i = 0; i < CH; i++) m_cap[i] = '0;
      m_capv = '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (capture[i]) begin
          m_cap[i] = m_data;
          m_capv[i] = 1'b1;
        end else if (cap_ack[i]) begin
          m_capv[i] = 1'b0;
        end
      end
      if (clear) begin
        m_data = '0; m_phase = 0; m_halted = 0; m_ovf = 0; m_done = 0;
      end else if (!m_halted && run) begin
        if (mode == 2'd2 && m_data == limit) begin
          m_halted = 1; m_done = 1;
        end else if (m_phase >= int'(prescaler)) begin
          m_phase = 0;
          if (mode == 2'd1 && m_data == MAXV) begin
            m_ovf = 1; m_done = 1; m_halted = 1;
          end else begin
            m_tick = 1;
            if (m_data == MAXV) m_ovf = 1;
            m_data = TL'((int'(m_data) + 1) % (1 << TL));
          end
        end else begin
          m_phase++;
        end
      end
    end
    e.data = m_data;
    e.tick = m_tick;
    e.ovf  = m_ovf;
    e.done = m_done;
    for (int i = 0; i < CH; i++) e.cap_data[i*TL +: TL] = m_cap[i];
    e.cap_valid = m_capv;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Monitor: outputs are registered, so every edge presents a new response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data",      32'(data),      32'(e.data));
        chk("tick",      32'(tick),      32'(e.tick));
        chk("overflow",  32'(overflow),  32'(e.ovf));
        chk("done",      32'(done),      32'(e.done));
        chk("cap_data",  32'(cap_data),  32'(e.cap_data));
        chk("cap_valid", 32'(cap_valid), 32'(e.cap_valid));
      end
    end
  end

  initial begin
    rst = 1'b1; prescaler = '0; run = 1'b0; mode = 2'd0; limit = '0;
    clear = 1'b0; capture = '0; cap_ack = '0;
    m_data = '0; m_phase = 0; m_halted = 0; m_ovf = 0; m_done = 0; m_tick = 0;
    m_capv = '0;
    for (int i = 0; i < CH; i++) m_cap[i] = '0;

    steps(2);
    rst = 1'b0;
    steps(2);
    chk("reset_data", 32'(data), 32'd0);

    // Basic FREE count with P=4, then pause and resume.
    prescaler = 8'd4; run = 1'b1;
    steps(100);
    chk("basic_data20", 32'(data), 32'd20);
    run = 1'b0;
    steps(7);
    chk("pause_data20", 32'(data), 32'd20);
    run = 1'b1;
    steps(3);
    run = 1'b0;
    steps(2);
    run = 1'b1;
    steps(6);

    // Wrap at P=0.
    clear = 1'b1; step(); clear = 1'b0;
    prescaler = 8'd0;
    steps(32);
    chk("wrap_data0", 32'(data), 32'd0);
    chk("wrap_ovf", 32'(overflow), 32'd1);
    steps(2);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clear_ovf", 32'(overflow), 32'd0);

    // SATURATE, with run toggled after the halt.
    mode = 2'd1;
    steps(35);
    run = 1'b0; steps(2); run = 1'b1; steps(3);
    chk("sat_data", 32'(data), 32'(MAXV));
    chk("sat_done", 32'(done), 32'd1);
    clear = 1'b1; step(); clear = 1'b0;
    steps(3);

    // ONESHOT limit 7, P=1.
    clear = 1'b1; step(); clear = 1'b0;
    mode = 2'd2; limit = 5'd7; prescaler = 8'd1;
    steps(14);
    chk("os_data7", 32'(data), 32'd7);
    chk("os_notdone", 32'(done), 32'd0);
    steps(1);
    mode = 2'd0;
    steps(5);
    chk("os_hold7", 32'(data), 32'd7);
    chk("os_done", 32'(done), 32'd1);
    mode = 2'd2; limit = 5'd0;
    clear = 1'b1; step(); clear = 1'b0;
    steps(1);
    chk("os_lim0_done", 32'(done), 32'd1);
    chk("os_lim0_tick", 32'(tick), 32'd0);

    // Capture on channel 2.
    mode = 2'd0; prescaler = 8'd0;
    clear = 1'b1; step(); clear = 1'b0;
    steps(9);
    capture = 4'b0100; step(); capture = '0;
    chk("cap2_data9", 32'(cap_data[2*TL +: TL]), 32'd9);
    cap_ack = 4'b0100; step(); cap_ack = '0;
    chk("cap2_acked", 32'(cap_valid[2]), 32'd0);
    capture = 4'b0100; cap_ack = 4'b0100; step();
    capture = '0; cap_ack = '0;
    chk("cap2_both", 32'(cap_valid[2]), 32'd1);

    // Asynchronous reset mid-run.
    clear = 1'b1; step(); clear = 1'b0;
    capture = 4'b0101; cap_ack = 4'b1010; step();
    capture = '0; cap_ack = '0;
    steps(12);
    chk("pre_rst_valid", 32'(cap_valid), 32'b0101);
    #2 rst = 1'b1;
    #1;
    chk("async_data", 32'(data), 32'd0);
    chk("async_valid", 32'(cap_valid), 32'd0);
    chk("async_cap", 32'(cap_data), 32'd0);
    step();
    rst = 1'b0;
    steps(5);

    // Randomised traffic.
    for (int k = 0; k < 2000; k++) begin
      rst       = ($urandom_range(0, 199) == 0);
      clear     = ($urandom_range(0, 49) == 0);
      run       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) limit = TL'($urandom);
      if ($urandom_range(0, 9) == 0) prescaler = PW'($urandom_range(0, 3));
      capture   = CH'($urandom) & CH'($urandom);
      cap_ack   = CH'($urandom) & CH'($urandom);
      step();
    end
    rst = 1'b0; clear = 1'b0; capture = '0; cap_ack = '0;
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timebase_stepper.md
# timebase_stepper

Parametrised, multi-mode successor to the logic analyser's single-mode time stepper. It divides `clk` by a runtime prescaler and advances a `TIME_LENGTH`-bit timestamp once per prescaler period. It supports free-running wrap, saturate-and-halt and one-shot-to-limit modes. It also provides `CHANNELS` independent capture registers that latch the timestamp on trigger events for the sample/trigger path.

## Interface

Parameters:

- `TIME_LENGTH`, 24, timestamp width in bits (≥2).
- `PRESCALER_WIDTH`, 32, prescaler width in bits.
- `CHANNELS`, 4, number of capture channels (≥1).

Ports:

- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `prescaler` input `PRESCALER_WIDTH`: divide value P; tick period is P+1 cycles.
- `run` input 1: count enable; low pauses counting.
- `mode` input 2: 0 FREE, 1 SATURATE, 2 ONESHOT, 3 behaves as FREE.
- `limit` input `TIME_LENGTH`: ONESHOT terminal value.
- `clear` input 1: synchronous clear of counter state.
- `capture` input `CHANNELS`: per-channel capture strobe.
- `cap_ack` input `CHANNELS`: per-channel valid clear.
- `data` output `TIME_LENGTH`: current timestamp.
- `tick` output 1: one-cycle pulse; high in the cycle `data` shows a new value.
- `overflow` output 1: sticky; set on max-value wrap or saturation.
- `done` output 1: sticky; high while in HALT.
- `cap_data` output `CHANNELS*TIME_LENGTH`: channel i occupies bits `[i*TIME_LENGTH +: TIME_LENGTH]`.
- `cap_valid` output `CHANNELS`: per-channel capture-held flag.

## Operation

- Internal divider `div` (`PRESCALER_WIDTH` bits) and state ∈ {COUNT, HALT}.
- **Reset:** `rst` high forces immediately (asynchronous), and holds while high:
  - `data`=0, `div`=0, `tick`=0, `overflow`=0, `done`=0.
  - `cap_data`=0, `cap_valid`=0.
  - state=COUNT.
- **Priority at each edge:** `rst` > `clear` > termination check > tick.
- **`clear`:**
  - Zeroes `data`, `div`, `overflow`, `done` and `tick`; sets state=COUNT.
  - Does not touch capture registers.
  - `clear` with `run`=1 in the same edge: clear wins, no tick.
- **Counting:** active only when state=COUNT and `run`=1. Each active edge:
  - If `div` ≥ P: `div`←0 and a tick event occurs.
  - Otherwise `div`←`div`+1.
  - The ≥ compare makes a mid-run prescaler decrease expire on the next active edge.
  - P=0 gives a tick every active cycle.
- **Pause:** `run`=0 freezes `div` and `data`. Resuming continues from the frozen `div`; the period is not restarted.
- **Tick event by mode:**
  - **FREE:** `data`←`data`+1, modulo 2^`TIME_LENGTH`. The wrap from all-ones to 0 sets `overflow`.
  - **SATURATE:** if `data` = all-ones, `data` holds, `overflow`←1, `done`←1, state←HALT, and no `tick` pulse is emitted. Otherwise `data`+1.
  - **ONESHOT:** `data`+1.
- **ONESHOT termination check:** in COUNT with `run`=1, if `data`==`limit`, then state←HALT and `done`←1, with no divider advance and no tick that edge.
  - `limit`=0 from cleared state: HALT on the first run cycle.
  - `limit` changed below `data`: counts on, wrapping, until equality.
- **HALT:**
  - `data` and `div` are frozen and `run` is ignored.
  - Left only by `clear` or `rst`.
  - A `mode` change in HALT has no effect until clear.
- **`mode` and `limit`** are sampled live at every edge; no shadow registers.
- **Capture, per channel i, independent of state and `run`:**
  - `capture[i]`=1 at an edge latches the pre-edge `data` value, i.e. the value before any same-edge increment, and sets `cap_valid[i]`.
  - A capture while `cap_valid[i]`=1 overwrites `cap_data[i]`.
  - `cap_ack[i]`=1 clears `cap_valid[i]` and leaves `cap_data[i]` unchanged.
  - Capture and ack at the same edge: capture wins; new data is latched and valid stays 1.

## Timing

- All outputs are registered; no combinational input-to-output paths.
- Tick latency:
  - First tick comes P+1 active edges after counting starts from `div`=0.
  - `data` and `tick` update at the same edge.
  - `tick` lasts exactly one cycle.
- `done` and `overflow` are visible the cycle after the causing edge and stay set until `clear`/`rst`.
- Capture latency is one edge: `cap_data` and `cap_valid` are valid the cycle after the `capture` strobe.
- `rst` deassertion: counting may begin at the first following edge where `run`=1.

## Test plan

- **Basic count, FREE, P=4:**
  - Stimulus: `run`=1 for 100 cycles from reset.
  - Response: `tick` every 5th cycle; `data`=20 at the end; `run`=0 then freezes `data`=20 and `div`.
- **Wrap, FREE, `TIME_LENGTH`=4, P=0:**
  - Stimulus: 16 active cycles.
  - Response: `data` steps 1..15 then 0; `overflow`=1 from the wrap onward.
  - `clear` returns `data`=0 and `overflow`=0.
- **SATURATE, `TIME_LENGTH`=4, P=0:**
  - Response: `data` reaches 15 and holds; `overflow`=1, `done`=1.
  - No further `tick`, even with `run` toggled.
  - Only `clear` restarts counting.
- **ONESHOT, `limit`=7, P=1:**
  - Response: `data`=7 after 14 active cycles, then HALT with `done`=1; `data` stays 7.
  - Separate case, `limit`=0: `done`=1 after 1 run cycle with no tick.
- **Capture, CH2:**
  - Strobe `capture[2]` at the tick edge where `data` goes 9→10: `cap_data[2]`=9 and `cap_valid[2]`=1.
  - `cap_ack[2]` clears valid and keeps 9.
  - Simultaneous capture+ack keeps valid=1 with the new value.
  - Other channels are unaffected.
- **Reset mid-run:**
  - Stimulus: `rst` pulse asserted between edges while `data`=13, `done`=0, `cap_valid`=4'b0101.
  - Response: all outputs go to 0 before the next edge; counting resumes from 0 after release.
